// File: rtl/ps2_pkg.sv
// Shared PS/2 types, command/response codes and frame helper for the host-side PS/2 blocks.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    RECOVER
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

  // Width of the shared inhibit / watchdog counter.
  localparam int PS2_TMR_W = 20;

  // Host-to-device frame body as shifted out LSB-first: data, odd parity, stop.
  function automatic logic [9:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between the controlling logic and the PS/2 host transmitter.
// Latency: none (wires only).
// Backpressure: valid/ready; the transmitter raises tx_ready only when it can take a byte.
// Ports: tx_data/tx_valid from master; tx_ready/tx_busy/tx_done/tx_error from slave.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_busy, tx_done, tx_error
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_busy, tx_done, tx_error
  );
endinterface

// File: rtl/ps2_line_sync.sv
// Conditions one raw PS/2 line: 2-FF synchronizer, stability filter, falling-edge strobe.
// Latency: filtered level and fall strobe follow a raw change by 2 + FILTER_LEN cycles.
// Backpressure: none; free-running, one instance per line, shareable with the receiver.
// Ports: raw in; filt (accepted level, resets high = idle bus) and one-cycle fall out.
module ps2_line_sync #(
  parameter int FILTER_LEN = 8
) (
  input  logic clock50,
  input  logic reset_n,
  input  logic raw,
  output logic filt,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      filt <= 1'b1;
      cnt  <= '0;
      fall <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      fall <= 1'b0;
      // cnt counts consecutive cycles the synchronized line disagrees with
      // the accepted level; any glitch back to the old level restarts it.
      if (s2 == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        filt <= s2;
        cnt  <= '0;
        fall <= filt & ~s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (request-to-send, 8 data bits, odd parity, stop, ACK).
// Latency: clk_oe rises 1 cycle after accept; data updates 1 cycle after each filtered clock fall.
// Backpressure: tx_ready only in IDLE; tx_valid while busy is ignored.
// Ports: clock50/reset_n; tx (slave handshake); keyboard_clk/keyboard_data raw lines in;
//        keyboard_clk_oe/keyboard_data_oe active-high pull-low enables out.
// Build option: define PS2_TX_TIMEOUT_EN to enable the start/frame watchdogs.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int INHIBIT_CYCLES = 6000,
  parameter int START_TIMEOUT  = 750_000,
  parameter int FRAME_TIMEOUT  = 100_000,
  parameter int FILTER_LEN     = 8
) (
  input  logic         clock50,
  input  logic         reset_n,
  ps2_host_tx_if.slave tx,
  input  logic         keyboard_clk,
  input  logic         keyboard_data,
  output logic         keyboard_clk_oe,
  output logic         keyboard_data_oe
);

  // Inhibit must last at least 100 us and all counts must fit the shared counter.
  if (INHIBIT_CYCLES * 10000 < CLK_HZ || INHIBIT_CYCLES > (1 << PS2_TMR_W) ||
      START_TIMEOUT > (1 << PS2_TMR_W) || FRAME_TIMEOUT > (1 << PS2_TMR_W)) begin : g_bad_params
    $error("ps2_host_tx: parameter out of range");
  end

  localparam logic [PS2_TMR_W-1:0] INH_LAST = PS2_TMR_W'(INHIBIT_CYCLES - 1);

  ps2_tx_state_t        state;
  ps2_tx_state_t        state_nxt;
  logic [PS2_TMR_W-1:0] cnt;
  logic [9:0]           shreg;
  logic [3:0]           bitcnt;
  logic                 req_first;
  logic                 data_q;
  logic                 done_q;
  logic                 error_q;
  logic                 timeout;

  logic clk_filt;
  logic clk_fall;
  logic dat_filt;
  logic data_fall_unused;

  ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_clk_sync (
    .clock50 (clock50),
    .reset_n (reset_n),
    .raw     (keyboard_clk),
    .filt    (clk_filt),
    .fall    (clk_fall)
  );

  ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_dat_sync (
    .clock50 (clock50),
    .reset_n (reset_n),
    .raw     (keyboard_data),
    .filt    (dat_filt),
    .fall    (data_fall_unused)
  );

`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [PS2_TMR_W-1:0] START_LAST = PS2_TMR_W'(START_TIMEOUT - 1);
  localparam logic [PS2_TMR_W-1:0] FRAME_LAST = PS2_TMR_W'(FRAME_TIMEOUT - 1);

  // A device edge arriving on the last watchdog cycle still counts as in time.
  always_comb begin
    timeout = 1'b0;
    if (!clk_fall) begin
      if (state == REQ && !req_first) begin
        timeout = (cnt == START_LAST);
      end else if (state == SHIFT || state == ACK) begin
        timeout = (cnt == FRAME_LAST);
      end
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tx.tx_valid) state_nxt = INHIBIT;
      INHIBIT: if (cnt == INH_LAST) state_nxt = REQ;
      REQ: begin
        if (timeout) state_nxt = RECOVER;
        else if (clk_fall && !req_first) state_nxt = SHIFT;
      end
      SHIFT: begin
        // Fall 10 (bitcnt 9 before increment) puts the stop bit out.
        if (timeout) state_nxt = RECOVER;
        else if (clk_fall && bitcnt == 4'd9) state_nxt = ACK;
      end
      ACK:     if (timeout || clk_fall) state_nxt = RECOVER;
      RECOVER: if (clk_filt && dat_filt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: shift register, bit count, shared counter, status pulses.
  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      shreg     <= '0;
      bitcnt    <= '0;
      req_first <= 1'b0;
      data_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      req_first <= (state == INHIBIT) && (state_nxt == REQ);

      // The counter restarts at every phase boundary except SHIFT->ACK, so the
      // frame watchdog spans first fall to ACK; in REQ it restarts at clock release.
      if (state == IDLE || req_first || (state_nxt != state && state != SHIFT)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (state == IDLE && tx.tx_valid) begin
        shreg  <= ps2_frame(tx.tx_data);
        bitcnt <= '0;
      end

      if (((state == REQ && !req_first) || state == SHIFT) && clk_fall && !timeout) begin
        data_q <= ~shreg[0];
        shreg  <= {1'b0, shreg[9:1]};
        bitcnt <= bitcnt + 1'b1;
      end

      if (state == ACK && clk_fall && !timeout) begin
        bitcnt  <= bitcnt + 1'b1;
        done_q  <= ~dat_filt;
        error_q <= dat_filt;
      end

      if (timeout) begin
        error_q <= 1'b1;
      end
    end
  end

  // Outputs decode from state so reset releases both lines asynchronously.
  always_comb begin
    keyboard_clk_oe  = 1'b0;
    keyboard_data_oe = 1'b0;
    case (state)
      INHIBIT: keyboard_clk_oe = 1'b1;
      REQ: begin
        keyboard_clk_oe  = req_first;
        keyboard_data_oe = 1'b1;
      end
      SHIFT:   keyboard_data_oe = data_q;
      default: ;
    endcase
  end

  assign tx.tx_ready = (state == IDLE);
  assign tx.tx_busy  = (state != IDLE);
  assign tx.tx_done  = done_q;
  assign tx.tx_error = error_q;

endmodule
